// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_pkg
// Purpose : Shared definitions for the credit-based stream link: the drain FSM
//           state encoding (also used by the receive side) and the helper that
//           sizes a credit counter able to hold 0..CREDITS.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package stream_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } link_state_e;

  // Width of a counter spanning 0..credits inclusive.
  function automatic int cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage : stream_pkg
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module  : credit_counter
// Purpose : Up/down credit counter that reloads to MAX on reset, saturates at
//           MAX and flags an increment that would exceed it.
// Ports   : clk, rst      clock / synchronous active-high reset
//           inc           one credit returned this cycle
//           dec           one credit spent this cycle
//           cnt_q         registered count
//           cnt_next      count that will be loaded at the next edge
//           ovf           increment arrived at MAX with no decrement
// Rev     : 1.0  initial release
// ============================================================================
module credit_counter #(
  parameter int MAX   = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX);

  always_comb begin
    cnt_next = cnt_q;
    ovf      = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == C_MAX) begin
        ovf = 1'b1;              // receiver returned more credits than exist
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end else if (dec && !inc) begin
      // The sender never spends from an empty pool; floor anyway.
      if (cnt_q != '0) begin
        cnt_next = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= C_MAX;
    end else begin
      cnt_q <= cnt_next;
    end
  end

endmodule : credit_counter
`default_nettype wire

// File: rtl/stream_credit_tx.sv
`default_nettype none
// ============================================================================
// Module  : stream_credit_tx
// Purpose : Transmit end of a credit-based link. Turns a valid/ready stream
//           into a valid-only link (no backpressure), spending one credit per
//           beat. A drain FSM (RUN/DRAIN/IDLE) quiesces the link so the far end
//           can be reset or powered down.
// Ports   : clk, rst      clock / synchronous active-high reset
//           valid_s,data_s upstream beat
//           ready_s       registered upstream ready
//           link_valid    registered link valid
//           link_data     registered link payload (not reset)
//           credit_in     one-cycle pulse = one credit returned
//           drain_req     level request to quiesce
//           idle          registered: link quiescent, all credits home
//           credit_cnt    current credit count
//           err           (only with CREDIT_TX_ERR_CHK_EN) sticky overflow flag
// Config  : CREDIT_TX_ERR_CHK_EN adds the sticky err output.
// Rev     : 1.0  initial release
// ============================================================================
module stream_credit_tx
  import stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int CREDITS    = 4,
  localparam int CNT_W      = cnt_width(CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_s,
  input  logic [DATA_WIDTH-1:0] data_s,
  output logic                  ready_s,
  output logic                  link_valid,
  output logic [DATA_WIDTH-1:0] link_data,
  input  logic                  credit_in,
  input  logic                  drain_req,
  output logic                  idle,
  output logic [CNT_W-1:0]      credit_cnt
`ifdef CREDIT_TX_ERR_CHK_EN
  ,
  output logic                  err
`endif
);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CREDITS);

  link_state_e           state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
  logic                  idle_q, idle_d;
  logic                  write;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_next;

  // ready_q is only high while credits remain, so a write never underflows.
  assign write = valid_s && ready_q;

`ifdef CREDIT_TX_ERR_CHK_EN
  logic ovf;
  logic err_q, err_d;
`else
  logic ovf_unused;
`endif

  credit_counter #(
    .MAX   (CREDITS),
    .CNT_W (CNT_W)
  ) u_credit_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (credit_in),
    .dec      (write),
    .cnt_q    (cnt_q),
    .cnt_next (cnt_next),
`ifdef CREDIT_TX_ERR_CHK_EN
    .ovf      (ovf)
`else
    .ovf      (ovf_unused)
`endif
  );

  // Drain FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end else if (cnt_next == C_FULL && !link_valid_q) begin
          // Every credit is home and the last beat has left the register.
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output register next values, computed from the look-ahead count/state so
  // that the last credit spent drops ready_s in the very next cycle.
  always_comb begin
    ready_d      = (cnt_next != '0) && (state_d == ST_RUN);
    idle_d       = (state_d == ST_IDLE);
    link_valid_d = write;
    link_data_d  = write ? data_s : link_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ready_q      <= 1'b1;
      link_valid_q <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      link_valid_q <= link_valid_d;
      idle_q       <= idle_d;
    end
  end

  // Payload is qualified by link_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    link_data_q <= link_data_d;
  end

`ifdef CREDIT_TX_ERR_CHK_EN
  always_comb begin
    err_d = err_q | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign ready_s    = ready_q;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign idle       = idle_q;
  assign credit_cnt = cnt_q;

endmodule : stream_credit_tx
`default_nettype wire

// File: tb/tb_stream_credit_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_credit_tx
// Purpose : Directed table-driven bench for stream_credit_tx (CREDITS=4,
//           DATA_WIDTH=8) plus a hand-written saturation/throughput sequence.
// Rev     : 1.0  initial release
// ============================================================================
module tb_stream_credit_tx;

  localparam int DW = 8;
  localparam int CR = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_s;
  logic [DW-1:0] data_s;
  logic          ready_s;
  logic          link_valid;
  logic [DW-1:0] link_data;
  logic          credit_in;
  logic          drain_req;
  logic          idle;
  logic [CW-1:0] credit_cnt;
`ifdef CREDIT_TX_ERR_CHK_EN
  logic          err;
`endif

  stream_credit_tx #(
    .DATA_WIDTH (DW),
    .CREDITS    (CR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_s    (valid_s),
    .data_s     (data_s),
    .ready_s    (ready_s),
    .link_valid (link_valid),
    .link_data  (link_data),
    .credit_in  (credit_in),
    .drain_req  (drain_req),
    .idle       (idle),
    .credit_cnt (credit_cnt)
`ifdef CREDIT_TX_ERR_CHK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          valid;
    logic [DW-1:0] data;
    logic          ci;
    logic          drain;
    logic          e_ready;
    logic          e_lv;
    logic [DW-1:0] e_ld;
    logic          ld_chk;
    logic          e_idle;
    logic [CW-1:0] e_cnt;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // rst valid data ci drain | ready lv ld ldchk idle cnt err
  task automatic add(input logic r, input logic v, input logic [DW-1:0] d,
                     input logic c, input logic dr, input logic er, input logic el,
                     input logic [DW-1:0] eld, input logic lc, input logic ei,
                     input logic [CW-1:0] ec, input logic ee);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ci = c; t.drain = dr;
    t.e_ready = er; t.e_lv = el; t.e_ld = eld; t.ld_chk = lc;
    t.e_idle = ei; t.e_cnt = ec; t.e_err = ee;
    vecs.push_back(t);
  endtask

  initial begin
    int beats;
    rst = 1'b1; valid_s = 1'b0; data_s = '0; credit_in = 1'b0; drain_req = 1'b0;

    // Reset state.
    add(1,0,8'h00,0,0, 1,0,8'h00,0,1,3'd4,0);
    // Spend all four credits with valid held; fifth beat is refused.
    add(0,1,8'h10,0,0, 1,1,8'h10,1,0,3'd3,0);
    add(0,1,8'h11,0,0, 1,1,8'h11,1,0,3'd2,0);
    add(0,1,8'h12,0,0, 1,1,8'h12,1,0,3'd1,0);
    add(0,1,8'h13,0,0, 0,1,8'h13,1,0,3'd0,0);
    add(0,1,8'h14,0,0, 0,0,8'h13,1,0,3'd0,0);
    add(0,1,8'h15,0,0, 0,0,8'h13,1,0,3'd0,0);
    // One credit at zero: ready next cycle, one beat, ready drops again.
    add(0,1,8'h20,1,0, 1,0,8'h13,1,0,3'd1,0);
    add(0,1,8'h21,0,0, 0,1,8'h21,1,0,3'd0,0);
    add(0,1,8'h22,0,0, 0,0,8'h21,1,0,3'd0,0);
    // Build count to 2, then write+credit each cycle: count steady, 1 beat/cycle.
    add(0,0,8'h00,1,0, 1,0,8'h21,1,0,3'd1,0);
    add(0,0,8'h00,1,0, 1,0,8'h21,1,0,3'd2,0);
    add(0,1,8'hA5,1,0, 1,1,8'hA5,1,0,3'd2,0);
    add(0,1,8'h3C,1,0, 1,1,8'h3C,1,0,3'd2,0);
    add(0,1,8'h77,1,0, 1,1,8'h77,1,0,3'd2,0);
    add(0,0,8'h00,0,0, 1,0,8'h77,1,0,3'd2,0);
    // Drop to 1 credit (3 outstanding), then drain.
    add(0,1,8'h55,0,0, 1,1,8'h55,1,0,3'd1,0);
    add(0,0,8'h00,0,1, 0,0,8'h55,1,0,3'd1,0);
    add(0,0,8'h00,1,1, 0,0,8'h55,1,0,3'd2,0);
    add(0,0,8'h00,1,1, 0,0,8'h55,1,0,3'd3,0);
    add(0,1,8'h66,1,1, 0,0,8'h55,1,1,3'd4,0);
    add(0,0,8'h00,0,1, 0,0,8'h55,1,1,3'd4,0);
    add(0,0,8'h00,0,0, 1,0,8'h55,1,0,3'd4,0);
    // Overflow at full count: saturates, err becomes sticky.
    add(0,0,8'h00,1,0, 1,0,8'h55,1,0,3'd4,1);
    add(0,0,8'h00,0,0, 1,0,8'h55,1,0,3'd4,1);
    // Drain aborted before IDLE; beat in the RUN->DRAIN cycle still goes out.
    add(0,1,8'h88,0,0, 1,1,8'h88,1,0,3'd3,1);
    add(0,1,8'h99,0,1, 0,1,8'h99,1,0,3'd2,1);
    add(0,0,8'h00,0,1, 0,0,8'h99,1,0,3'd2,1);
    add(0,0,8'h00,0,0, 1,0,8'h99,1,0,3'd2,1);
    add(0,0,8'h00,1,0, 1,0,8'h99,1,0,3'd3,1);
    add(0,0,8'h00,1,0, 1,0,8'h99,1,0,3'd4,1);
    // IDLE held off while a beat is still on link_valid.
    add(0,1,8'hBB,0,1, 0,1,8'hBB,1,0,3'd3,1);
    add(0,0,8'h00,1,1, 0,0,8'hBB,1,0,3'd4,1);
    add(0,0,8'h00,0,1, 0,0,8'hBB,1,1,3'd4,1);
    add(0,0,8'h00,0,0, 1,0,8'hBB,1,0,3'd4,1);
    // Mid-operation reset discards the beat and reloads the count.
    add(0,1,8'hCC,0,0, 1,1,8'hCC,1,0,3'd3,1);
    add(1,1,8'hDD,1,0, 1,0,8'h00,0,1,3'd4,0);
    add(0,0,8'h00,0,0, 1,0,8'h00,0,0,3'd4,0);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      valid_s   = vecs[i].valid;
      data_s    = vecs[i].data;
      credit_in = vecs[i].ci;
      drain_req = vecs[i].drain;
      @(posedge clk);
      #1;
      check("ready_s",    i, 32'(ready_s),    32'(vecs[i].e_ready));
      check("link_valid", i, 32'(link_valid), 32'(vecs[i].e_lv));
      check("idle",       i, 32'(idle),       32'(vecs[i].e_idle));
      check("credit_cnt", i, 32'(credit_cnt), 32'(vecs[i].e_cnt));
      if (vecs[i].ld_chk) check("link_data", i, 32'(link_data), 32'(vecs[i].e_ld));
`ifdef CREDIT_TX_ERR_CHK_EN
      check("err", i, 32'(err), 32'(vecs[i].e_err));
`endif
    end

    // Hand sequence: from a full pool, hold valid for 10 cycles with no
    // credits returned; exactly CREDITS beats must appear on the link.
    beats = 0;
    valid_s = 1'b1; credit_in = 1'b0; drain_req = 1'b0; rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_s = DW'(8'h40 + k);
      @(posedge clk);
      #1;
      if (link_valid) begin
        check("sat_data", k, 32'(link_data), 32'(8'h40 + beats));
        beats++;
      end
    end
    check("sat_beats", 0, 32'(beats),      32'(CR));
    check("sat_ready", 0, 32'(ready_s),    32'(0));
    check("sat_cnt",   0, 32'(credit_cnt), 32'(0));
    valid_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_credit_tx
`default_nettype wire
